// File: rtl/rk4_step_sequencer.sv
// Sequences the four slope evaluations of one RK4 step, accumulates k1+2k2+2k3+k4 and
// forms y0 + h*sum/6 in Q8.8. Define RK4_SAT_EN to saturate the result and report OVERFLOW.
module rk4_step_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        START,
    input  logic [15:0] X0_IN,
    input  logic [15:0] Y0_IN,
    input  logic [15:0] H_IN,
    output logic [15:0] X_OUT,
    output logic [15:0] Y_OUT,
    output logic [15:0] H_OUT,
    output logic [15:0] K_OUT,
    output logic        F_REQ,
    input  logic        F_ACK,
    input  logic [31:0] DY_DX_IN,
    output logic [15:0] Y_NEXT,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERFLOW
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACC, S_FINAL, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  s_q, s_d;
    logic [15:0] x0_q, x0_d, y0_q, y0_d, h_q, h_d;
    logic [31:0] slope_q, slope_d;
    logic [34:0] acc_q, acc_d;
    logic [15:0] y_next_q, y_next_d;

    logic [34:0] slope_ext;
    logic [50:0] p_full;
    logic [34:0] p;
    logic [49:0] incr_full;
    logic [33:0] incr;
    logic [34:0] sum;
    logic [15:0] y_res;

    // Operands are sign-extended by hand, so unsigned products and logical shifts
    // followed by truncation give the arithmetic (floor) results.
    always_comb begin
        slope_ext = {{3{slope_q[31]}}, slope_q};
        p_full    = {{35{h_q[15]}}, h_q} * {{16{acc_q[34]}}, acc_q};
        p         = 35'(p_full >> 16);
        incr_full = {{15{p[34]}}, p} * 50'd10923;
        incr      = 34'(incr_full >> 16);
        sum       = {{19{y0_q[15]}}, y0_q} + {incr[33], incr};
    end

`ifdef RK4_SAT_EN
    logic sum_ovf;
    logic ovf_q, ovf_d;

    always_comb begin
        sum_ovf = !((&sum[34:15]) || !(|sum[34:15]));
        y_res   = sum_ovf ? (sum[34] ? 16'h8000 : 16'h7FFF) : sum[15:0];
        ovf_d   = (state_q == S_FINAL) ? sum_ovf : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign OVERFLOW = ovf_q;
`else
    assign y_res    = 16'(sum);
    assign OVERFLOW = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        h_d      = h_q;
        slope_d  = slope_q;
        acc_d    = acc_q;
        y_next_d = y_next_q;
        case (state_q)
            S_IDLE: if (START) begin
                x0_d    = X0_IN;
                y0_d    = Y0_IN;
                h_d     = H_IN;
                acc_d   = '0;
                s_d     = 2'd0;
                state_d = S_REQ;
            end
            S_REQ: if (F_ACK) begin
                slope_d = DY_DX_IN;
                state_d = S_ACC;
            end
            S_ACC: begin
                // Middle stages carry weight 2 in the RK4 sum.
                acc_d = acc_q + ((s_q == 2'd1 || s_q == 2'd2) ? {slope_ext[33:0], 1'b0} : slope_ext);
                if (s_q == 2'd3) begin
                    state_d = S_FINAL;
                end else begin
                    s_d     = s_q + 2'd1;
                    state_d = S_REQ;
                end
            end
            S_FINAL: begin
                y_next_d = y_res;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            s_q      <= 2'd0;
            x0_q     <= '0;
            y0_q     <= '0;
            h_q      <= '0;
            slope_q  <= '0;
            acc_q    <= '0;
            y_next_q <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            h_q      <= h_d;
            slope_q  <= slope_d;
            acc_q    <= acc_d;
            y_next_q <= y_next_d;
        end
    end

    // slope_q holds the previous stage's slope, whose Q8.8 truncation is this stage's k.
    always_comb begin
        H_OUT = 16'h0000;
        K_OUT = 16'h0000;
        case (s_q)
            2'd1, 2'd2: begin H_OUT = {h_q[15], h_q[15:1]}; K_OUT = slope_q[23:8]; end
            2'd3:       begin H_OUT = h_q;                  K_OUT = slope_q[23:8]; end
            default:    ;
        endcase
    end

    assign X_OUT  = x0_q;
    assign Y_OUT  = y0_q;
    assign F_REQ  = (state_q == S_REQ);
    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = (state_q == S_DONE);
    assign Y_NEXT = y_next_q;
endmodule
